pe_mul_sched: RTL and testbench
===============================

# pe_mul_sched

Job sequencer and accumulator for the `pe_mul` multiplier array. It accepts a dot-product job descriptor of length N, then streams N operand beats. Each beat is one shared weight byte plus DATA_COPIES activation bytes, fed through `pe_mul`. The block accumulates the DATA_COPIES products per lane with saturation and presents the final lane sums on a valid/ready result port. It sits between the NPU core's operand fetch logic and the post-processing/writeback stage.

## Interface
- DATA_WIDTH, 8: operand width (signed)
- DATA_COPIES, 32: lanes in the multiplier array
- ACC_WIDTH, 24: per-lane accumulator width (signed), must be ≥ 2*DATA_WIDTH
- LEN_WIDTH, 10: job length field width
- i_clk  in  1  sole clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_job_valid  in  1  job descriptor valid
- o_job_ready  out  1  descriptor accepted; high only in IDLE
- i_job_len  in  LEN_WIDTH  number of operand beats N (0 legal)
- i_op_valid  in  1  operand beat valid
- o_op_ready  out  1  beat accepted; high only in RUN
- i_wdata  in  DATA_WIDTH  signed weight, broadcast to all lanes
- i_mdata  in  DATA_COPIES*DATA_WIDTH  signed activations, lane i at [DATA_WIDTH*i +: DATA_WIDTH]
- o_res_valid  out  1  result valid
- i_res_ready  in  1  result consumed
- o_res_data  out  DATA_COPIES*ACC_WIDTH  lane sums, lane i at [ACC_WIDTH*i +: ACC_WIDTH]
- o_sat  out  1  sticky per job: some lane saturated; valid with o_res_valid
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- **IDLE**
  - On a job handshake (i_job_valid & o_job_ready): latch N, clear the beat counter, all accumulators, o_sat and the product-valid bit.
  - Next state is RUN if N≠0, or OUT if N=0, which emits all-zero lanes with o_sat=0.
- **RUN**
  - Each beat handshake (i_op_valid & o_op_ready) increments the beat counter.
  - The registered product stage captures the `pe_mul` outputs and sets the product-valid bit. The bit is cleared in any cycle without a beat handshake.
  - The handshake that takes the counter to N moves the state to DRAIN.
  - Bubbles (i_op_valid low) stall the job without affecting results.
- **DRAIN**: exactly one cycle, letting the last product reach the accumulators. Then go to OUT.
- **OUT**
  - o_res_valid=1; o_res_data and o_sat are held stable until i_res_ready.
  - On the result handshake, go to IDLE. o_job_ready first rises in the following cycle; there is no same-cycle job overlap.
- **Accumulation**
  - When the product-valid bit is set, each lane adds its 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH.
  - The add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets o_sat, which stays set until the next job is accepted.
- **Reset**
  - i_rst returns the block to IDLE and zeroes all registers and outputs: o_res_valid=0, o_res_data=0, o_sat=0, o_busy=0, o_op_ready=0.
  - o_job_ready=1 from the first cycle after reset.
  - Reset mid-job drops the job silently. No result is produced.
- Inputs not handshaked (valid without ready) are ignored. The upstream must hold a beat until it is accepted.

## Timing
- The `pe_mul` array is combinational. Products are registered once inside this block, so accumulation is a 2-stage pipeline.
- Last beat handshake in cycle c: DRAIN in c+1, o_res_valid=1 in c+2.
- Minimum job, N=1 with beat in first RUN cycle:
  - job handshake in cycle t → RUN in t+1 → DRAIN in t+2 → OUT in t+3.
- N=0: job handshake in t → o_res_valid in t+1.
- Throughput: one beat per cycle in RUN. Job-to-job overhead is 3 cycles (DRAIN, OUT, IDLE) plus result backpressure.

## Configuration
- PE_MUL_SCHED_RELU_EN
  - Defined: each lane of o_res_data is forced to 0 when negative. Accumulators and o_sat are unaffected.
  - Undefined: o_res_data is the raw saturated lane sum.

## Structure
- Shared package pe_mul_sched_pkg holds:
  - the state encoding localparams (IDLE=0, RUN=1, DRAIN=2, OUT=3);
  - the saturation-limit constants / saturating-add function, parameterised on ACC_WIDTH.
- One sub-module: a single `pe_mul` instance (DATA_WIDTH, DATA_COPIES passed through). The product register, accumulators and FSM live in this block.

## Test plan
- N=1, w=2, all lanes m=3 → every lane 6, o_sat=0, o_res_valid exactly 3 cycles after job handshake.
- N=4, w=-1, m=127 all lanes, i_op_valid toggling every other cycle → every lane -508. o_res_valid rises 2 cycles after the 4th beat handshake.
- ACC_WIDTH=16, N=3, w=-128, m=-128 → lanes clamp to 32767, o_sat=1. The next job (N=1, w=1, m=1) → lanes 1, o_sat=0.
- N=0 → all-zero result in cycle after job handshake. Hold i_res_ready=0 for 5 cycles → data stable, o_job_ready=0, then handshake → IDLE.
- Assert i_rst in RUN after 2 of N=5 beats → next cycle o_busy=0, o_job_ready=1, no o_res_valid. A fresh N=1, w=1, m=5 job → lanes 5.
- With PE_MUL_SCHED_RELU_EN: N=1, w=-1, lane0 m=10, lane1 m=-10 → lane0 0, lane1 10.

Source files
------------

// File: rtl/pe_mul_sched_pkg.sv
// Shared state encoding and accumulator saturation limits for pe_mul_sched.
// Limits are computed as 65-bit signed values, so ACC_WIDTH may be at most 64.
package pe_mul_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        OUT   = ST_OUT
    } state_t;

    function automatic logic signed [64:0] acc_max(input int acc_w);
        return (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    endfunction

    function automatic logic signed [64:0] acc_min(input int acc_w);
        return -(65'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/pe_mul_sched_pe_mul.sv
// pe_mul: combinational signed multiplier array, one shared weight times
// DATA_COPIES activations, full 2*DATA_WIDTH products per lane.
module pe_mul #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32
) (
    input  logic [DATA_WIDTH-1:0]               i_w,
    input  logic [DATA_COPIES*DATA_WIDTH-1:0]   i_m,
    output logic [DATA_COPIES*2*DATA_WIDTH-1:0] o_p
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] w_w_ext;
    assign w_w_ext = PW'($signed(i_w));

    for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
        logic signed [PW-1:0] w_m_ext;
        assign w_m_ext            = PW'($signed(i_m[DATA_WIDTH*g +: DATA_WIDTH]));
        assign o_p[PW*g +: PW]    = w_w_ext * w_m_ext;
    end

endmodule

// File: rtl/pe_mul_sched.sv
// Job sequencer + saturating per-lane accumulator around pe_mul.
// Optional macro PE_MUL_SCHED_RELU_EN clamps negative lane results to 0 at the output.
module pe_mul_sched
    import pe_mul_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int ACC_WIDTH   = 24,
    parameter int LEN_WIDTH   = 10
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_job_valid,
    output logic                                o_job_ready,
    input  logic [LEN_WIDTH-1:0]                i_job_len,
    input  logic                                i_op_valid,
    output logic                                o_op_ready,
    input  logic [DATA_WIDTH-1:0]               i_wdata,
    input  logic [DATA_COPIES*DATA_WIDTH-1:0]   i_mdata,
    output logic                                o_res_valid,
    input  logic                                i_res_ready,
    output logic [DATA_COPIES*ACC_WIDTH-1:0]    o_res_data,
    output logic                                o_sat,
    output logic                                o_busy
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [64:0] L_ACC_MAX = acc_max(ACC_WIDTH);
    localparam logic signed [64:0] L_ACC_MIN = acc_min(ACC_WIDTH);

    state_t                                 r_state;
    logic [LEN_WIDTH-1:0]                   r_len;
    logic [LEN_WIDTH-1:0]                   r_cnt;
    logic [DATA_COPIES-1:0][PW-1:0]         r_prod;
    logic                                   r_prod_vld;
    logic [DATA_COPIES-1:0][ACC_WIDTH-1:0]  r_acc;
    logic                                   r_sat;
    logic                                   r_job_ready;
    logic                                   r_op_ready;
    logic                                   r_res_valid;
    logic                                   r_busy;

    logic [DATA_COPIES*PW-1:0]              w_prod_flat;
    logic [DATA_COPIES-1:0][ACC_WIDTH-1:0]  w_acc_nxt;
    logic [DATA_COPIES-1:0]                 w_lane_sat;
    logic [LEN_WIDTH-1:0]                   w_cnt_nxt;
    logic                                   w_job_hs;
    logic                                   w_op_hs;

    assign w_job_hs  = i_job_valid & r_job_ready;
    assign w_op_hs   = i_op_valid & r_op_ready;
    assign w_cnt_nxt = r_cnt + LEN_WIDTH'(1);

    pe_mul #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DATA_COPIES (DATA_COPIES)
    ) u_pe_mul (
        .i_w (i_wdata),
        .i_m (i_mdata),
        .o_p (w_prod_flat)
    );

    // One guard bit on the sum is enough to detect overflow of a single add.
    for (genvar g = 0; g < DATA_COPIES; g++) begin : g_acc
        logic signed [ACC_WIDTH:0] w_sum;
        logic signed [64:0]        w_sum_ext;
        logic                      w_hi;
        logic                      w_lo;

        assign w_sum      = (ACC_WIDTH+1)'($signed(r_acc[g])) + (ACC_WIDTH+1)'($signed(r_prod[g]));
        assign w_sum_ext  = 65'(w_sum);
        assign w_hi       = w_sum_ext > L_ACC_MAX;
        assign w_lo       = w_sum_ext < L_ACC_MIN;
        assign w_lane_sat[g] = w_hi | w_lo;
        assign w_acc_nxt[g]  = w_hi ? L_ACC_MAX[ACC_WIDTH-1:0] :
                               w_lo ? L_ACC_MIN[ACC_WIDTH-1:0] : w_sum[ACC_WIDTH-1:0];

`ifdef PE_MUL_SCHED_RELU_EN
        assign o_res_data[ACC_WIDTH*g +: ACC_WIDTH] = r_acc[g][ACC_WIDTH-1] ? '0 : r_acc[g];
`else
        assign o_res_data[ACC_WIDTH*g +: ACC_WIDTH] = r_acc[g];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_job_ready <= 1'b1;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_prod_vld <= w_op_hs;
            if (w_op_hs) r_prod <= w_prod_flat;
            if (r_prod_vld) begin
                r_acc <= w_acc_nxt;
                if (|w_lane_sat) r_sat <= 1'b1;
            end

            case (r_state)
                IDLE: if (w_job_hs) begin
                    r_len       <= i_job_len;
                    r_cnt       <= '0;
                    r_acc       <= '0;
                    r_sat       <= 1'b0;
                    r_prod_vld  <= 1'b0;
                    r_job_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    if (i_job_len == '0) begin
                        r_state     <= OUT;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_state     <= RUN;
                        r_op_ready  <= 1'b1;
                    end
                end
                RUN: if (w_op_hs) begin
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_len) begin
                        r_state    <= DRAIN;
                        r_op_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_state     <= OUT;
                    r_res_valid <= 1'b1;
                end
                OUT: if (i_res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_job_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_job_ready = r_job_ready;
    assign o_op_ready  = r_op_ready;
    assign o_res_valid = r_res_valid;
    assign o_sat       = r_sat;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_pe_mul_sched.sv
// Self-checking bench for pe_mul_sched: directed scenarios plus random jobs
// against a per-lane integer reference model.
module tb_pe_mul_sched;

    localparam int DW = 8;
    localparam int DC = 8;
    localparam int AW = 16;
    localparam int LW = 10;
    localparam int MAXB = 16;

    logic               clk;
    logic               i_rst;
    logic               i_job_valid;
    logic               o_job_ready;
    logic [LW-1:0]      i_job_len;
    logic               i_op_valid;
    logic               o_op_ready;
    logic [DW-1:0]      i_wdata;
    logic [DC*DW-1:0]   i_mdata;
    logic               o_res_valid;
    logic               i_res_ready;
    logic [DC*AW-1:0]   o_res_data;
    logic               o_sat;
    logic               o_busy;

    int checks;
    int failures;
    int cyc;

    int w_arr [MAXB];
    int m_arr [MAXB][DC];

    pe_mul_sched #(
        .DATA_WIDTH  (DW),
        .DATA_COPIES (DC),
        .ACC_WIDTH   (AW),
        .LEN_WIDTH   (LW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_job_valid (i_job_valid),
        .o_job_ready (o_job_ready),
        .i_job_len   (i_job_len),
        .i_op_valid  (i_op_valid),
        .o_op_ready  (o_op_ready),
        .i_wdata     (i_wdata),
        .i_mdata     (i_mdata),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_data  (o_res_data),
        .o_sat       (o_sat),
        .o_busy      (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: sum of w*m per lane, clamped to the AW-bit range after every beat.
    task automatic model(input int len, output logic [DC*AW-1:0] exp_d, output logic exp_s);
        longint hi, lo, acc;
        hi = (longint'(1) <<< (AW-1)) - 1;
        lo = -(longint'(1) <<< (AW-1));
        exp_s = 1'b0;
        exp_d = '0;
        for (int l = 0; l < DC; l++) begin
            acc = 0;
            for (int b = 0; b < len; b++) begin
                acc = acc + longint'(w_arr[b]) * longint'(m_arr[b][l]);
                if (acc > hi) begin acc = hi; exp_s = 1'b1; end
                if (acc < lo) begin acc = lo; exp_s = 1'b1; end
            end
`ifdef PE_MUL_SCHED_RELU_EN
            if (acc < 0) acc = 0;
`endif
            exp_d[AW*l +: AW] = acc[AW-1:0];
        end
    endtask

    // Drives one job; returns at the negedge of the first cycle with o_res_valid high.
    task automatic do_job(input int len, input int mode, output int t_job, output int t_last,
                          output int t_res, output bit tmo);
        bit got;
        logic [DC*DW-1:0] v;
        tmo = 0; t_job = 0; t_last = 0; t_res = 0;
        i_job_len = LW'(len);
        i_job_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_job_ready) begin got = 1; break; end
            @(posedge clk); #1;
        end
        t_job = cyc;
        @(posedge clk); #1;
        i_job_valid = 1'b0;
        if (!got) begin tmo = 1; return; end
        for (int b = 0; b < len; b++) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                i_op_valid = 1'b0;
                @(posedge clk); #1;
            end
            for (int l = 0; l < DC; l++) v[DW*l +: DW] = DW'(m_arr[b][l]);
            i_op_valid = 1'b1;
            i_wdata = DW'(w_arr[b]);
            i_mdata = v;
            got = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (o_op_ready) begin got = 1; break; end
                @(posedge clk); #1;
            end
            if (!got) begin i_op_valid = 1'b0; tmo = 1; return; end
            t_last = cyc;
            @(posedge clk); #1;
        end
        i_op_valid = 1'b0;
        i_mdata = $urandom();
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_res_valid) begin got = 1; break; end
            @(posedge clk); #1;
        end
        if (!got) begin tmo = 1; return; end
        t_res = cyc;
    endtask

    task automatic take_result();
        i_res_ready = 1'b1;
        @(posedge clk); #1;
        i_res_ready = 1'b0;
    endtask

    task automatic fill_const(input int len, input int w, input int m);
        for (int b = 0; b < len; b++) begin
            w_arr[b] = w;
            for (int l = 0; l < DC; l++) m_arr[b][l] = m;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        checks++; if (o_res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", o_res_valid); end
        checks++; if (o_res_data !== '0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", o_res_data); end
        checks++; if (o_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", o_sat); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_op_ready !== 1'b0) begin failures++; $display("FAIL reset_op_ready got=%b exp=0", o_op_ready); end
        checks++; if (o_job_ready !== 1'b1) begin failures++; $display("FAIL reset_job_ready got=%b exp=1", o_job_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_min_job();
        int tj, tl, tr; bit tmo; logic [DC*AW-1:0] ed; logic es;
        fill_const(1, 2, 3);
        model(1, ed, es);
        do_job(1, 0, tj, tl, tr, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL min_job_timeout got=timeout exp=result"); end
        checks++; if (o_res_data !== ed) begin failures++; $display("FAIL min_job_data got=%h exp=%h", o_res_data, ed); end
        checks++; if (o_sat !== es) begin failures++; $display("FAIL min_job_sat got=%b exp=%b", o_sat, es); end
        checks++; if (tr - tj != 3) begin failures++; $display("FAIL min_job_latency got=%0d exp=3", tr - tj); end
        take_result();
    endtask

    task automatic test_bubbles();
        int tj, tl, tr; bit tmo; logic [DC*AW-1:0] ed; logic es;
        fill_const(4, -1, 127);
        model(4, ed, es);
        do_job(4, 1, tj, tl, tr, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL bubbles_timeout got=timeout exp=result"); end
        checks++; if (o_res_data !== ed) begin failures++; $display("FAIL bubbles_data got=%h exp=%h", o_res_data, ed); end
        checks++; if (o_sat !== es) begin failures++; $display("FAIL bubbles_sat got=%b exp=%b", o_sat, es); end
        checks++; if (tr - tl != 2) begin failures++; $display("FAIL bubbles_latency got=%0d exp=2", tr - tl); end
        take_result();
    endtask

    task automatic test_saturation();
        int tj, tl, tr; bit tmo; logic [DC*AW-1:0] ed; logic es;
        fill_const(3, -128, -128);
        model(3, ed, es);
        do_job(3, 0, tj, tl, tr, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL sat_timeout got=timeout exp=result"); end
        checks++; if (o_res_data !== ed) begin failures++; $display("FAIL sat_data got=%h exp=%h", o_res_data, ed); end
        checks++; if (o_sat !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", o_sat); end
        take_result();
        fill_const(1, 1, 1);
        model(1, ed, es);
        do_job(1, 0, tj, tl, tr, tmo);
        checks++; if (o_res_data !== ed) begin failures++; $display("FAIL sat_next_data got=%h exp=%h", o_res_data, ed); end
        checks++; if (o_sat !== 1'b0) begin failures++; $display("FAIL sat_next_flag got=%b exp=0", o_sat); end
        take_result();
    endtask

    task automatic test_zero_len();
        int tj, tl, tr; bit tmo, bad; logic [DC*AW-1:0] ed; logic es;
        model(0, ed, es);
        do_job(0, 0, tj, tl, tr, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL zero_timeout got=timeout exp=result"); end
        checks++; if (tr - tj != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", tr - tj); end
        checks++; if (o_res_data !== ed || o_sat !== 1'b0) begin failures++; $display("FAIL zero_data got=%h/%b exp=%h/0", o_res_data, o_sat, ed); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            if (o_res_data !== ed || o_res_valid !== 1'b1 || o_job_ready !== 1'b0) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL zero_hold got=unstable exp=stable data valid=1 job_ready=0"); end
        take_result();
        @(negedge clk);
        checks++; if (o_job_ready !== 1'b1 || o_busy !== 1'b0 || o_res_valid !== 1'b0)
            begin failures++; $display("FAIL zero_idle got=jr%b busy%b rv%b exp=jr1 busy0 rv0", o_job_ready, o_busy, o_res_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_job();
        int tj, tl, tr; bit tmo, bad; logic [DC*AW-1:0] ed; logic es;
        i_job_len = LW'(5);
        i_job_valid = 1'b1;
        @(negedge clk);
        checks++; if (o_job_ready !== 1'b1) begin failures++; $display("FAIL rstmid_job_ready got=%b exp=1", o_job_ready); end
        @(posedge clk); #1;
        i_job_valid = 1'b0;
        i_op_valid = 1'b1;
        i_wdata = 8'd3;
        i_mdata = {DC{8'd7}};
        repeat (2) begin @(posedge clk); #1; end
        i_op_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0 || o_job_ready !== 1'b1 || o_res_valid !== 1'b0)
            begin failures++; $display("FAIL rstmid_idle got=busy%b jr%b rv%b exp=busy0 jr1 rv0", o_busy, o_job_ready, o_res_valid); end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_res_valid !== 1'b0) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rstmid_no_result got=valid exp=none"); end
        @(posedge clk); #1;
        fill_const(1, 1, 5);
        model(1, ed, es);
        do_job(1, 0, tj, tl, tr, tmo);
        checks++; if (tmo || o_res_data !== ed) begin failures++; $display("FAIL rstmid_fresh got=%h exp=%h", o_res_data, ed); end
        take_result();
    endtask

    task automatic test_relu_case();
        int tj, tl, tr; bit tmo; logic [DC*AW-1:0] ed; logic es;
        w_arr[0] = -1;
        for (int l = 0; l < DC; l++) m_arr[0][l] = int'($urandom_range(0, 255)) - 128;
        m_arr[0][0] = 10;
        m_arr[0][1] = -10;
        model(1, ed, es);
        do_job(1, 0, tj, tl, tr, tmo);
        checks++; if (tmo || o_res_data !== ed) begin failures++; $display("FAIL relu_data got=%h exp=%h", o_res_data, ed); end
        take_result();
    endtask

    task automatic test_random();
        int tj, tl, tr, len, hold; bit tmo; logic [DC*AW-1:0] ed, d0; logic es;
        for (int j = 0; j < 10; j++) begin
            len = $urandom_range(0, MAXB);
            for (int b = 0; b < MAXB; b++) begin
                w_arr[b] = int'($urandom_range(0, 255)) - 128;
                for (int l = 0; l < DC; l++) m_arr[b][l] = int'($urandom_range(0, 255)) - 128;
            end
            model(len, ed, es);
            do_job(len, 2, tj, tl, tr, tmo);
            checks++; if (tmo) begin failures++; $display("FAIL rand%0d_timeout got=timeout exp=result", j); end
            checks++; if (o_res_data !== ed || o_sat !== es)
                begin failures++; $display("FAIL rand%0d_data got=%h/%b exp=%h/%b", j, o_res_data, o_sat, ed, es); end
            checks++;
            if ((len > 0 && tr - tl != 2) || (len == 0 && tr - tj != 1))
                begin failures++; $display("FAIL rand%0d_latency got=%0d/%0d len=%0d", j, tr - tj, tr - tl, len); end
            d0 = o_res_data;
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin @(posedge clk); @(negedge clk); end
            checks++; if (o_res_data !== d0 || o_res_valid !== 1'b1)
                begin failures++; $display("FAIL rand%0d_hold got=%h exp=%h", j, o_res_data, d0); end
            take_result();
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        i_rst = 1'b0; i_job_valid = 1'b0; i_job_len = '0; i_op_valid = 1'b0;
        i_wdata = '0; i_mdata = '0; i_res_ready = 1'b0;
        test_reset();
        test_min_job();
        test_bubbles();
        test_saturation();
        test_zero_len();
        test_reset_mid_job();
        test_relu_case();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
